// File: rtl/mux_arr_rr_arbiter.sv
// Round-robin arbiter feeding a shared 2:1 array mux into a one-entry registered output slot.
// Optional per-requester grant counters are enabled by defining MUX_ARR_ARB_CNT_EN.
module mux_arr_rr_arbiter #(
    parameter int WIDTH = 2,
    parameter int ELEMS = 2,
    parameter int CNTW  = 16
) (
    input  logic                         CLK,
    input  logic                         ASYNCRESETN,
    input  logic [ELEMS-1:0][WIDTH-1:0]  I0,
    input  logic                         I0_valid,
    output logic                         I0_ready,
    input  logic [ELEMS-1:0][WIDTH-1:0]  I1,
    input  logic                         I1_valid,
    output logic                         I1_ready,
    output logic [ELEMS-1:0][WIDTH-1:0]  O,
    output logic                         O_valid,
    input  logic                         O_ready,
    output logic                         O_src,
    output logic                         S
`ifdef MUX_ARR_ARB_CNT_EN
    ,
    input  logic                         cnt_clr,
    output logic [CNTW-1:0]              gnt0_cnt,
    output logic [CNTW-1:0]              gnt1_cnt
`endif
);

    // Saturating increment shared by both grant counters.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == {CNTW{1'b1}}) ? v : v + CNTW'(1);
    endfunction

    logic                         free_s;
    logic                         grant_vld_s;
    logic                         grant_idx_s;
    logic                         last_grant_r;
    logic [ELEMS-1:0][WIDTH-1:0]  mux_data_s;

    // Grant decision: the slot must be free; contention goes to the requester not served last.
    always_comb begin
        free_s      = !O_valid || O_ready;
        grant_vld_s = 1'b0;
        grant_idx_s = last_grant_r;
        if (free_s) begin
            case ({I1_valid, I0_valid})
                2'b01: begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = 1'b0;
                end
                2'b10: begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = 1'b1;
                end
                2'b11: begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = !last_grant_r;
                end
                default: begin
                    grant_vld_s = 1'b0;
                    grant_idx_s = last_grant_r;
                end
            endcase
        end else begin
            grant_vld_s = 1'b0;
            grant_idx_s = last_grant_r;
        end
    end

    // Select and handshakes; with no grant the select parks on the last winner.
    always_comb begin
        S          = grant_idx_s;
        I0_ready   = grant_vld_s && (grant_idx_s == 1'b0);
        I1_ready   = grant_vld_s && (grant_idx_s == 1'b1);
        mux_data_s = I0;
        if (grant_idx_s) begin
            mux_data_s = I1;
        end else begin
            mux_data_s = I0;
        end
    end

    // Output slot: a load wins over a drain so back-to-back transfers leave no bubble.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            O            <= '0;
            O_valid      <= 1'b0;
            O_src        <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (grant_vld_s) begin
            O            <= mux_data_s;
            O_valid      <= 1'b1;
            O_src        <= grant_idx_s;
            last_grant_r <= grant_idx_s;
        end else if (O_valid && O_ready) begin
            O_valid      <= 1'b0;
        end
    end

`ifdef MUX_ARR_ARB_CNT_EN
    // Requester 0 grant counter; a clear coinciding with a grant restarts at one.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            gnt0_cnt <= '0;
        end else if (cnt_clr) begin
            gnt0_cnt <= (grant_vld_s && !grant_idx_s) ? CNTW'(1) : '0;
        end else if (grant_vld_s && !grant_idx_s) begin
            gnt0_cnt <= sat_inc(gnt0_cnt);
        end
    end

    // Requester 1 grant counter, same clear/saturation behaviour.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            gnt1_cnt <= '0;
        end else if (cnt_clr) begin
            gnt1_cnt <= (grant_vld_s && grant_idx_s) ? CNTW'(1) : '0;
        end else if (grant_vld_s && grant_idx_s) begin
            gnt1_cnt <= sat_inc(gnt1_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_mux_arr_rr_arbiter.sv
// Directed bench for mux_arr_rr_arbiter: expected payloads are queued at issue and
// popped by a monitor whenever the consumer takes O.
module tb_mux_arr_rr_arbiter;

`ifdef MUX_ARR_ARB_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic            CLK = 1'b0;
    logic            ASYNCRESETN;
    logic [1:0][1:0] I0, I1, O;
    logic            I0_valid, I1_valid, I0_ready, I1_ready;
    logic            O_valid, O_ready, O_src, S;
`ifdef MUX_ARR_ARB_CNT_EN
    logic            cnt_clr;
    logic [CW-1:0]   gnt0_cnt, gnt1_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [4:0] sb_q[$];

    mux_arr_rr_arbiter #(.WIDTH(2), .ELEMS(2), .CNTW(CW)) dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .I0(I0), .I0_valid(I0_valid), .I0_ready(I0_ready),
        .I1(I1), .I1_valid(I1_valid), .I1_ready(I1_ready),
        .O(O), .O_valid(O_valid), .O_ready(O_ready), .O_src(O_src), .S(S)
`ifdef MUX_ARR_ARB_CNT_EN
        , .cnt_clr(cnt_clr), .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the consumer takes O, compare it with the oldest expectation.
    always @(negedge CLK) begin
        if (ASYNCRESETN && O_valid && O_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_output", {27'd0, O_src, O}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_payload", {27'd0, O_src, O}, {27'd0, sb_q.pop_front()});
            end
        end
    end

    // One clock of stimulus; eg is the hand-computed grant (0, 1, or 2 for none).
    task automatic cyc(input logic v0, input logic [3:0] p0, input logic v1,
                       input logic [3:0] p1, input logic ordy, input int eg);
        I0_valid = v0; I0 = p0;
        I1_valid = v1; I1 = p1;
        O_ready  = ordy;
        @(negedge CLK);
        chk("i0_ready", {31'd0, I0_ready}, (eg == 0) ? 32'd1 : 32'd0);
        chk("i1_ready", {31'd0, I1_ready}, (eg == 1) ? 32'd1 : 32'd0);
        if (eg == 0) begin
            chk("sel", {31'd0, S}, 32'd0);
            sb_q.push_back({1'b0, p0});
        end else if (eg == 1) begin
            chk("sel", {31'd0, S}, 32'd1);
            sb_q.push_back({1'b1, p1});
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        ASYNCRESETN = 1'b0;
        I0 = 4'h0; I1 = 4'h0; I0_valid = 1'b0; I1_valid = 1'b0; O_ready = 1'b0;
`ifdef MUX_ARR_ARB_CNT_EN
        cnt_clr = 1'b0;
`endif
        #23;
        ASYNCRESETN = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_o_valid", {31'd0, O_valid}, 32'd0);
        chk("rst_o", {28'd0, O}, 32'd0);
        chk("rst_o_src", {31'd0, O_src}, 32'd0);
        chk("rst_sel_idle", {31'd0, S}, 32'd1);

        // 1: single request, payload {10,01}, visible one cycle later
        cyc(1'b1, 4'b1001, 1'b0, 4'h0, 1'b1, 0);
        chk("t1_o_valid", {31'd0, O_valid}, 32'd1);
        chk("t1_o", {28'd0, O}, 32'h9);
        chk("t1_o_src", {31'd0, O_src}, 32'd0);

        // 2: contention at full rate; last winner was 0 so grants go 1,0,1,0
        cyc(1'b1, 4'hA, 1'b1, 4'hB, 1'b1, 1);
        cyc(1'b1, 4'hA, 1'b1, 4'hC, 1'b1, 0);
        cyc(1'b1, 4'hD, 1'b1, 4'hC, 1'b1, 1);
        cyc(1'b1, 4'hD, 1'b1, 4'hE, 1'b1, 0);

        // 3: slot full and stalled, both requests held pending
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 4'h6, 1'b1, 4'h9, 1'b0, 2);
            chk("t3_o_hold", {28'd0, O}, 32'hD);
            chk("t3_valid_hold", {31'd0, O_valid}, 32'd1);
        end
        cyc(1'b1, 4'h6, 1'b1, 4'h9, 1'b1, 1);

        // 4: drain and reload in the same cycle keeps O_valid high
        cyc(1'b0, 4'h6, 1'b1, 4'h5, 1'b1, 1);
        chk("t4_no_bubble", {31'd0, O_valid}, 32'd1);
        chk("t4_o", {28'd0, O}, 32'h5);
        cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 2);
        chk("t4_drained", {31'd0, O_valid}, 32'd0);

        // 5: asynchronous reset while a payload sits unconsumed
        cyc(1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 0);
        cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2);
        chk("t5_pre_valid", {31'd0, O_valid}, 32'd1);
        #1;
        ASYNCRESETN = 1'b0;
        #1;
        chk("t5_async_valid", {31'd0, O_valid}, 32'd0);
        chk("t5_async_o", {28'd0, O}, 32'd0);
        chk("t5_async_src", {31'd0, O_src}, 32'd0);
        sb_q.delete();
        #1;
        ASYNCRESETN = 1'b1;
        @(posedge CLK);
        #1;
        cyc(1'b1, 4'h7, 1'b1, 4'h8, 1'b1, 0);
        cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 2);

`ifdef MUX_ARR_ARB_CNT_EN
        // 6: counters saturate at 15 with CNTW=4, then clear
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 4'(i), 1'b0, 4'h0, 1'b1, 0);
        end
        cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 2);
        chk("t6_gnt0_sat", {28'd0, gnt0_cnt}, 32'd15);
        chk("t6_gnt1", {28'd0, gnt1_cnt}, 32'd0);
        cnt_clr = 1'b1;
        cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 2);
        cnt_clr = 1'b0;
        chk("t6_clr0", {28'd0, gnt0_cnt}, 32'd0);
        chk("t6_clr1", {28'd0, gnt1_cnt}, 32'd0);
        cnt_clr = 1'b1;
        cyc(1'b0, 4'h0, 1'b1, 4'h2, 1'b1, 1);
        cnt_clr = 1'b0;
        chk("t6_clr_grant", {28'd0, gnt1_cnt}, 32'd1);
        cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 2);
`endif

        chk("sb_leftover", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
